// File: rtl/uart_frame_parser.sv
// Framed-command decoder: hunts for SOF, checks CMD/LEN/payload/XOR checksum,
// streams payload through a small FIFO and issues one ACK/NAK byte per frame.
module uart_frame_parser #(
   parameter int unsigned MAX_LEN     = 16,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned TIMEOUT_CYC = 500_000
) (
   input  logic       clk_50mhz,
   input  logic       reset_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       rx_error,
   output logic [7:0] cmd,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       out_last,
   input  logic       out_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_send,
   input  logic       rsp_busy,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [7:0]  SOF = 8'hAA;
   localparam logic [7:0]  ACK = 8'h06;
   localparam logic [7:0]  NAK = 8'h15;
   localparam logic [1:0]  E_NONE = 2'b00;
   localparam logic [1:0]  E_CHK  = 2'b01;
   localparam logic [1:0]  E_LEN  = 2'b10;
   localparam logic [1:0]  E_RX   = 2'b11;

   typedef enum logic [2:0] {S_HUNT, S_CMD, S_LEN, S_PAY, S_CHK, S_RESP} state_e;

   state_e          state_q, state_d;
   logic [7:0]      chk_q, chk_d, cnt_q, cnt_d;
   logic            ovf_q, ovf_d;
   logic [1:0]      code_q, code_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [7:0]      cmd_q, cmd_d, rsp_data_q, rsp_data_d;
   logic            rsp_send_q, rsp_send_d, frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
   logic [1:0]      err_code_q, err_code_d;
   logic            in_frame, timeout, rx_bad, push, push_last;

   logic [8:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic            full, pop, push_ok;

   assign in_frame = (state_q == S_CMD) || (state_q == S_LEN) ||
                     (state_q == S_PAY) || (state_q == S_CHK);
   assign timeout  = in_frame && !rx_valid && (tmr_q == TW'(TIMEOUT_CYC - 1));
   assign rx_bad   = rx_valid && rx_error;

   assign full     = (count_q == CW'(FIFO_DEPTH));
   assign pop      = (count_q != '0) && out_ready;
   assign push_ok  = push && (!full || pop);

   // State register
   always_ff @(posedge clk_50mhz or negedge reset_n) begin
      if (!reset_n) state_q <= S_HUNT;
      else          state_q <= state_d;
   end

   // Next-state decode; timeout overrides everything while inside a frame
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_HUNT: if (rx_valid && !rx_error && rx_data == SOF) state_d = S_CMD;
         S_CMD:  if (rx_bad) state_d = S_RESP;
                 else if (rx_valid) state_d = S_LEN;
         S_LEN:  if (rx_bad) state_d = S_RESP;
                 else if (rx_valid) begin
                    if (rx_data > 8'(MAX_LEN)) state_d = S_RESP;
                    else if (rx_data == 8'd0)  state_d = S_CHK;
                    else                       state_d = S_PAY;
                 end
         S_PAY:  if (rx_bad) state_d = S_RESP;
                 else if (rx_valid && cnt_q == 8'd1) state_d = S_CHK;
         S_CHK:  if (rx_valid) state_d = S_RESP;
         S_RESP: if (!rsp_busy) state_d = S_HUNT;
         default: state_d = S_HUNT;
      endcase
      if (timeout) state_d = S_HUNT;
   end

   // Datapath and output next values
   always_comb begin
      chk_d       = chk_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      code_d      = code_q;
      cmd_d       = cmd_q;
      rsp_data_d  = rsp_data_q;
      rsp_send_d  = 1'b0;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = err_code_q;
      push        = 1'b0;
      push_last   = 1'b0;
      tmr_d       = (!in_frame || rx_valid) ? '0 : tmr_q + TW'(1);
      unique case (state_q)
         S_HUNT: if (rx_valid && !rx_error && rx_data == SOF) ovf_d = 1'b0;
         S_CMD:  if (rx_bad) code_d = E_RX;
                 else if (rx_valid) begin
                    cmd_d      = rx_data;
                    chk_d      = rx_data;
                    err_code_d = E_NONE;
                 end
         S_LEN:  if (rx_bad) code_d = E_RX;
                 else if (rx_valid) begin
                    chk_d  = chk_q ^ rx_data;
                    cnt_d  = rx_data;
                    code_d = (rx_data > 8'(MAX_LEN)) ? E_LEN : E_NONE;
                 end
         S_PAY:  if (rx_bad) code_d = E_RX;
                 else if (rx_valid) begin
                    chk_d     = chk_q ^ rx_data;
                    cnt_d     = cnt_q - 8'd1;
                    push      = 1'b1;
                    push_last = (cnt_q == 8'd1);
                    if (full && !pop) ovf_d = 1'b1;
                 end
         S_CHK:  if (rx_valid) begin
                    if (rx_error)            code_d = E_RX;
                    else if (ovf_q)          code_d = E_LEN;
                    else if (rx_data == chk_q) code_d = E_NONE;
                    else                     code_d = E_CHK;
                 end
         S_RESP: if (!rsp_busy) begin
                    rsp_send_d  = 1'b1;
                    rsp_data_d  = (code_q == E_NONE) ? ACK : NAK;
                    frame_ok_d  = (code_q == E_NONE);
                    frame_err_d = (code_q != E_NONE);
                    err_code_d  = code_q;
                 end
         default: ;
      endcase
      if (timeout) begin
         frame_err_d = 1'b1;
         err_code_d  = E_RX;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk_50mhz or negedge reset_n) begin
      if (!reset_n) begin
         chk_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         code_q      <= E_NONE;
         tmr_q       <= '0;
         cmd_q       <= '0;
         rsp_data_q  <= '0;
         rsp_send_q  <= 1'b0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= E_NONE;
      end else begin
         chk_q       <= chk_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         code_q      <= code_d;
         tmr_q       <= tmr_d;
         cmd_q       <= cmd_d;
         rsp_data_q  <= rsp_data_d;
         rsp_send_q  <= rsp_send_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
      end
   end

   // Payload FIFO; push into a full FIFO is accepted only alongside a pop
   always_ff @(posedge clk_50mhz or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= {push_last, rx_data};
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         unique case ({push_ok, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign cmd       = cmd_q;
   assign out_data  = mem_q[rd_ptr_q][7:0];
   assign out_last  = mem_q[rd_ptr_q][8];
   assign out_valid = (count_q != '0);
   assign rsp_data  = rsp_data_q;
   assign rsp_send  = rsp_send_q;
   assign frame_ok  = frame_ok_q;
   assign frame_err = frame_err_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser (small FIFO and short timeout).
module tb_uart_frame_parser;

   localparam int unsigned TMO = 200;

   logic       clk_50mhz = 1'b0;
   logic       reset_n;
   logic [7:0] rx_data;
   logic       rx_valid, rx_error;
   logic [7:0] cmd, out_data, rsp_data;
   logic       out_valid, out_last, out_ready;
   logic       rsp_send, rsp_busy, frame_ok, frame_err;
   logic [1:0] err_code;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pop = 0, n_rsp = 0, n_ok = 0, n_err = 0, cyc = 0;
   int s_pop, s_rsp, s_ok, s_err;
   logic [7:0] last_rsp = 8'h00;
   logic [7:0] pop_data [64];
   logic       pop_last [64];

   uart_frame_parser #(.MAX_LEN(16), .FIFO_DEPTH(4), .TIMEOUT_CYC(TMO)) dut (
      .clk_50mhz(clk_50mhz), .reset_n(reset_n),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error),
      .cmd(cmd), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
      .out_ready(out_ready), .rsp_data(rsp_data), .rsp_send(rsp_send), .rsp_busy(rsp_busy),
      .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
   );

   always #10 clk_50mhz = ~clk_50mhz;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Record pops and response/frame pulses on the falling edge
   always @(posedge clk_50mhz) cyc++;
   always @(negedge clk_50mhz) begin
      if (out_valid && out_ready && n_pop < 64) begin
         pop_data[n_pop] = out_data;
         pop_last[n_pop] = out_last;
         n_pop++;
      end
      if (rsp_send) begin
         n_rsp++;
         last_rsp = rsp_data;
      end
      if (frame_ok) begin
         n_ok++;
         check_eq("ok_with_send", 32'(rsp_send), 32'd1);
      end
      if (frame_err) n_err++;
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk_50mhz);
      #2;
   endtask

   task automatic send(input logic [7:0] b, input logic e = 1'b0);
      @(posedge clk_50mhz); #2;
      rx_data = b; rx_valid = 1'b1; rx_error = e;
      @(posedge clk_50mhz); #2;
      rx_valid = 1'b0; rx_error = 1'b0;
   endtask

   task automatic snap();
      s_pop = n_pop; s_rsp = n_rsp; s_ok = n_ok; s_err = n_err;
   endtask

   initial begin
      reset_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_error = 1'b0;
      out_ready = 1'b0; rsp_busy = 1'b0;
      idle(3);
      reset_n = 1'b1;
      idle(1);
      check_eq("rst_out_valid", 32'(out_valid), 0);
      check_eq("rst_out_data",  32'(out_data), 0);
      check_eq("rst_rsp_data",  32'(rsp_data), 0);
      check_eq("rst_rsp_send",  32'(rsp_send), 0);
      check_eq("rst_cmd",       32'(cmd), 0);
      check_eq("rst_err_code",  32'(err_code), 0);
      check_eq("rst_pulses",    32'({frame_ok, frame_err}), 0);

      // 1: good frame, two payload bytes
      out_ready = 1'b1; snap();
      send(8'hAA); send(8'h01); send(8'h02); send(8'h10); send(8'h20); send(8'h33);
      idle(8);
      check_eq("t1_pops", 32'(n_pop - s_pop), 2);
      check_eq("t1_b0",   32'({pop_last[s_pop], pop_data[s_pop]}), 32'h010);
      check_eq("t1_b1",   32'({pop_last[s_pop+1], pop_data[s_pop+1]}), 32'h120);
      check_eq("t1_cmd",  32'(cmd), 32'h01);
      check_eq("t1_rsps", 32'(n_rsp - s_rsp), 1);
      check_eq("t1_rsp",  32'(last_rsp), 32'h06);
      check_eq("t1_ok",   32'(n_ok - s_ok), 1);
      check_eq("t1_err",  32'(n_err - s_err), 0);

      // 2: bad checksum
      snap();
      send(8'hAA); send(8'h01); send(8'h02); send(8'h10); send(8'h20); send(8'h34);
      idle(8);
      check_eq("t2_pops", 32'(n_pop - s_pop), 2);
      check_eq("t2_rsp",  32'(last_rsp), 32'h15);
      check_eq("t2_err",  32'(n_err - s_err), 1);
      check_eq("t2_code", 32'(err_code), 2'b01);

      // 3: junk before SOF, zero-length frame
      snap();
      send(8'h55); send(8'hAA); send(8'h05); send(8'h00); send(8'h05);
      idle(8);
      check_eq("t3_pops", 32'(n_pop - s_pop), 0);
      check_eq("t3_rsps", 32'(n_rsp - s_rsp), 1);
      check_eq("t3_rsp",  32'(last_rsp), 32'h06);
      check_eq("t3_cmd",  32'(cmd), 32'h05);
      check_eq("t3_code", 32'(err_code), 0);

      // 4: LEN too big, NAK straight after LEN, then a good frame
      snap();
      send(8'hAA); send(8'h01); send(8'h20);
      idle(5);
      check_eq("t4_rsps", 32'(n_rsp - s_rsp), 1);
      check_eq("t4_rsp",  32'(last_rsp), 32'h15);
      check_eq("t4_code", 32'(err_code), 2'b10);
      snap();
      send(8'hAA); send(8'h03); send(8'h01); send(8'h44); send(8'h46);
      idle(8);
      check_eq("t4b_rsp", 32'(last_rsp), 32'h06);
      check_eq("t4b_ok",  32'(n_ok - s_ok), 1);
      check_eq("t4b_pop", 32'({pop_last[s_pop], pop_data[s_pop]}), 32'h144);

      // 5: FIFO overflow with consumer stalled
      out_ready = 1'b0; snap();
      send(8'hAA); send(8'h02); send(8'h06);
      for (int i = 1; i <= 6; i++) send(8'(i));
      send(8'h03);
      idle(8);
      check_eq("t5_rsp",   32'(last_rsp), 32'h15);
      check_eq("t5_code",  32'(err_code), 2'b10);
      check_eq("t5_valid", 32'(out_valid), 1);
      out_ready = 1'b1;
      idle(8);
      check_eq("t5_pops", 32'(n_pop - s_pop), 4);
      for (int i = 0; i < 4; i++)
         check_eq("t5_byte", 32'({pop_last[s_pop+i], pop_data[s_pop+i]}), 32'(i + 1));
      check_eq("t5_empty", 32'(out_valid), 0);

      // 6: mid-frame timeout, no response byte
      snap();
      send(8'hAA); send(8'h01);
      idle(TMO / 2);
      check_eq("t6_early", 32'(n_err - s_err), 0);
      for (int i = 0; i < int'(TMO) && n_err == s_err; i++) idle(1);
      check_eq("t6_err",  32'(n_err - s_err), 1);
      check_eq("t6_rsps", 32'(n_rsp - s_rsp), 0);
      check_eq("t6_code", 32'(err_code), 2'b11);
      snap();
      send(8'hAA); send(8'h05); send(8'h00); send(8'h05);
      idle(8);
      check_eq("t6_hunt", 32'(last_rsp), 32'h06);
      check_eq("t6_ok",   32'(n_ok - s_ok), 1);

      // 7: transmitter busy holds off the response
      rsp_busy = 1'b1; snap();
      send(8'hAA); send(8'h07); send(8'h00); send(8'h07);
      idle(10);
      check_eq("t7_held", 32'(n_rsp - s_rsp), 0);
      rsp_busy = 1'b0;
      idle(5);
      check_eq("t7_rsps", 32'(n_rsp - s_rsp), 1);
      check_eq("t7_rsp",  32'(last_rsp), 32'h06);

      // 8: receiver framing error mid-frame
      snap();
      send(8'hAA); send(8'h01); send(8'h02, 1'b1);
      idle(8);
      check_eq("t8_rsp",  32'(last_rsp), 32'h15);
      check_eq("t8_code", 32'(err_code), 2'b11);

      // 9: async reset in the middle of payload
      out_ready = 1'b0;
      send(8'hAA); send(8'h01); send(8'h03); send(8'h11); send(8'h22);
      idle(1);
      check_eq("t9_pre_valid", 32'(out_valid), 1);
      reset_n = 1'b0;
      #3;
      check_eq("t9_valid", 32'(out_valid), 0);
      check_eq("t9_cmd",   32'(cmd), 0);
      check_eq("t9_code",  32'(err_code), 0);
      check_eq("t9_rspd",  32'(rsp_data), 0);
      idle(1);
      reset_n = 1'b1;
      out_ready = 1'b1; snap();
      send(8'h33); send(8'h11);
      idle(8);
      check_eq("t9_norsp", 32'(n_rsp - s_rsp), 0);
      send(8'hAA); send(8'h05); send(8'h00); send(8'h05);
      idle(8);
      check_eq("t9_rsp", 32'(last_rsp), 32'h06);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
